link_sequencer: RTL and testbench

LINK_SEQUENCER -- requirements
Module: link_sequencer

---
 rtl/link_sequencer.sv | 147 ++++++++++++++
 tb/tb_link_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/link_sequencer.sv
// Receives UART-style frames, hands each payload byte to an external encryptor,
// buffers the ciphertext in a small FIFO and feeds it to a transmitter in order.
`default_nettype none

module link_sequencer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int ENC_TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          run,
  output logic                          read_enable,
  input  logic                          rx_done,
  input  logic [9:0]                    rx_frame,
  output logic                          encrypt_enable,
  output logic [7:0]                    enc_in,
  input  logic                          enc_done,
  input  logic [7:0]                    enc_out,
  output logic                          send_enable,
  output logic [7:0]                    tx_data,
  input  logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    frame_err_cnt,
  output logic [7:0]                    timeout_cnt,
  output logic                          err
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int TW    = $clog2(ENC_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_RX, ENCRYPT, WAIT_ENC} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_WAIT_BUSY, TX_WAIT_DONE} tx_state_t;

  rx_state_t rx_state, rx_next;
  tx_state_t tx_state, tx_next;

  logic [TW-1:0] timer;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] head, tail;
  logic          push, pop, load_enc, frame_bad, timeout_hit;

  // Receive path
  always_comb begin
    rx_next     = rx_state;
    load_enc    = 1'b0;
    frame_bad   = 1'b0;
    timeout_hit = 1'b0;
    push        = 1'b0;
    case (rx_state)
      IDLE:     if (run && fifo_count < CW'(FIFO_DEPTH)) rx_next = WAIT_RX;
      WAIT_RX:
        if (rx_done) begin
          if (!rx_frame[0] && rx_frame[9]) begin
            rx_next  = ENCRYPT;
            load_enc = 1'b1;
          end else begin
            rx_next   = IDLE;
            frame_bad = 1'b1;
          end
        end
      ENCRYPT:  rx_next = WAIT_ENC;
      WAIT_ENC:
        // a response arriving on the final timer cycle still counts
        if (enc_done) begin
          push    = 1'b1;
          rx_next = IDLE;
        end else if (timer == TW'(ENC_TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          rx_next     = IDLE;
        end
      default:  rx_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state       <= IDLE;
      timer          <= '0;
      read_enable    <= 1'b0;
      encrypt_enable <= 1'b0;
      enc_in         <= 8'h00;
      err            <= 1'b0;
      frame_err_cnt  <= 8'h00;
      timeout_cnt    <= 8'h00;
    end else begin
      rx_state       <= rx_next;
      timer          <= (rx_state == WAIT_ENC) ? timer + 1'b1 : '0;
      read_enable    <= (rx_next == WAIT_RX);
      encrypt_enable <= (rx_next == ENCRYPT);
      if (load_enc) enc_in <= rx_frame[8:1];
      err            <= frame_bad | timeout_hit;
      if (frame_bad && frame_err_cnt != 8'hFF) frame_err_cnt <= frame_err_cnt + 8'd1;
      if (timeout_hit && timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
    end
  end

  // Transmit path
  assign pop = (tx_state == TX_IDLE) && (fifo_count != '0) && !tx_busy;

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:      if (pop) tx_next = TX_START;
      TX_START:     tx_next = TX_WAIT_BUSY;
      TX_WAIT_BUSY: if (tx_busy) tx_next = TX_WAIT_DONE;
      TX_WAIT_DONE: if (!tx_busy) tx_next = TX_IDLE;
      default:      tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state    <= TX_IDLE;
      send_enable <= 1'b0;
      tx_data     <= 8'h00;
    end else begin
      tx_state    <= tx_next;
      send_enable <= (tx_next == TX_START);
      if (pop) tx_data <= mem[head];
    end
  end

  // FIFO bookkeeping; storage itself needs no reset since count gates reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head       <= '0;
      tail       <= '0;
      fifo_count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= enc_out;
  end

endmodule

`default_nettype wire

// File: tb/tb_link_sequencer.sv
// Directed, table-driven bench for link_sequencer with a simple transmitter model.
`default_nettype none

module tb_link_sequencer;

  localparam int DEPTH = 4;
  localparam int TMO   = 64;

  logic       clk = 1'b0, rst_n = 1'b0, run = 1'b0;
  logic       rx_done = 1'b0, enc_done = 1'b0, tx_busy = 1'b0;
  logic [9:0] rx_frame = '0;
  logic [7:0] enc_out = '0;
  logic       read_enable, encrypt_enable, send_enable, err;
  logic [7:0] enc_in, tx_data, frame_err_cnt, timeout_cnt;
  logic [$clog2(DEPTH):0] fifo_count;

  link_sequencer #(.FIFO_DEPTH(DEPTH), .ENC_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .read_enable(read_enable),
    .rx_done(rx_done), .rx_frame(rx_frame), .encrypt_enable(encrypt_enable),
    .enc_in(enc_in), .enc_done(enc_done), .enc_out(enc_out),
    .send_enable(send_enable), .tx_data(tx_data), .tx_busy(tx_busy),
    .fifo_count(fifo_count), .frame_err_cnt(frame_err_cnt),
    .timeout_cnt(timeout_cnt), .err(err)
  );

  always #5 clk = ~clk;

  int         total = 0, bad = 0;
  int         exp_ferr = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  logic       hold_busy = 1'b0;
  int         busy_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transmitter model: checks each started byte against arrival order
  always @(negedge clk) begin
    if (send_enable) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_send: got tx_data %0h expected no send", tx_data);
      end else begin
        exp_b = exp_q.pop_front();
        check("tx_data", {24'h0, tx_data}, {24'h0, exp_b});
      end
      busy_cnt = 3;
    end else if (busy_cnt > 0) begin
      busy_cnt = busy_cnt - 1;
    end
    tx_busy = hold_busy || (busy_cnt != 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_read(input string name);
    int n = 0;
    while (!read_enable && n < 300) begin
      tick();
      n++;
    end
    check(name, {31'h0, read_enable}, 32'h1);
  endtask

  // Deliver one frame; valid frames return with the DUT in WAIT_ENC
  task automatic do_rx(input logic [9:0] frame, input logic [7:0] data, input logic valid);
    wait_read("read_enable_ready");
    rx_frame = frame;
    rx_done  = 1'b1;
    tick();
    rx_done  = 1'b0;
    if (valid) begin
      check("encrypt_enable_pulse", {31'h0, encrypt_enable}, 32'h1);
      check("enc_in", {24'h0, enc_in}, {24'h0, data});
      tick();
      check("encrypt_enable_one_cycle", {31'h0, encrypt_enable}, 32'h0);
    end else begin
      exp_ferr++;
      check("err_on_bad_frame", {31'h0, err}, 32'h1);
      check("no_encrypt_on_bad", {31'h0, encrypt_enable}, 32'h0);
      check("frame_err_cnt", {24'h0, frame_err_cnt}, exp_ferr);
      tick();
      check("err_one_cycle", {31'h0, err}, 32'h0);
    end
  endtask

  task automatic do_enc(input logic [7:0] val);
    enc_done = 1'b1;
    enc_out  = val;
    exp_q.push_back(val);
    tick();
    enc_done = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((fifo_count != 0 || exp_q.size() != 0 || busy_cnt != 0) && n < 500) begin
      tick();
      n++;
    end
    check("drain_fifo_empty", {29'h0, fifo_count}, 32'h0);
    check("drain_all_sent", exp_q.size(), 32'h0);
  endtask

  typedef struct {
    logic [9:0] frame;
    logic [7:0] data;
    logic [7:0] enc;
    logic       valid;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{10'b1_10100101_0, 8'hA5, 8'h3C, 1'b1};
    vecs[1] = '{10'b0_10100101_0, 8'h00, 8'h00, 1'b0};
    vecs[2] = '{10'b1_00000000_1, 8'h00, 8'h00, 1'b0};
    vecs[3] = '{10'b1_11111111_0, 8'hFF, 8'h00, 1'b1};
    vecs[4] = '{10'b1_00000001_0, 8'h01, 8'h81, 1'b1};
    vecs[5] = '{10'b0_11110000_1, 8'h00, 8'h00, 1'b0};
    vecs[6] = '{10'b1_01011010_0, 8'h5A, 8'hC3, 1'b1};

    // Reset state
    #1;
    check("rst_read_enable", {31'h0, read_enable}, 32'h0);
    check("rst_send_enable", {31'h0, send_enable}, 32'h0);
    check("rst_fifo_count", {29'h0, fifo_count}, 32'h0);
    check("rst_enc_in", {24'h0, enc_in}, 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("no_read_without_run", {31'h0, read_enable}, 32'h0);
    run = 1'b1;
    tick();
    check("read_after_run", {31'h0, read_enable}, 32'h1);

    // Table vectors
    for (int i = 0; i < 7; i++) begin
      do_rx(vecs[i].frame, vecs[i].data, vecs[i].valid);
      if (vecs[i].valid) begin
        tick();
        do_enc(vecs[i].enc);
      end else begin
        wait_read("read_reasserts_after_err");
      end
    end
    drain();

    // Backpressure: transmitter busy, fill FIFO
    hold_busy = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      do_rx({1'b1, 8'(8'h11 * (i + 1)), 1'b0}, 8'(8'h11 * (i + 1)), 1'b1);
      do_enc(8'(8'hB0 + i));
    end
    check("full_count", {29'h0, fifo_count}, 32'h4);
    repeat (5) tick();
    check("full_blocks_read", {31'h0, read_enable}, 32'h0);
    hold_busy = 1'b0;
    drain();
    wait_read("read_returns_after_drain");

    // Push coincident with pop at count 2
    hold_busy = 1'b1;
    tick();
    do_rx(10'b1_00100010_0, 8'h22, 1'b1);
    do_enc(8'hD1);
    do_rx(10'b1_00110011_0, 8'h33, 1'b1);
    do_enc(8'hD2);
    do_rx(10'b1_01000100_0, 8'h44, 1'b1);
    check("pre_coincident_count", {29'h0, fifo_count}, 32'h2);
    hold_busy = 1'b0;
    do_enc(8'hD3);
    check("coincident_count", {29'h0, fifo_count}, 32'h2);
    drain();

    // Encryptor timeout
    do_rx(10'b1_01110111_0, 8'h77, 1'b1);
    begin
      int n = 0;
      while (!err && n < 200) begin
        tick();
        n++;
      end
      check("timeout_latency", n, TMO);
    end
    check("timeout_cnt", {24'h0, timeout_cnt}, 32'h1);
    check("timeout_count_unchanged", {29'h0, fifo_count}, 32'h0);
    tick();
    check("timeout_err_one_cycle", {31'h0, err}, 32'h0);
    enc_done = 1'b1;
    enc_out  = 8'hEE;
    tick();
    enc_done = 1'b0;
    tick();
    check("stray_enc_done_ignored", {29'h0, fifo_count}, 32'h0);

    // Reset mid-frame with bytes buffered
    hold_busy = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      do_rx({1'b1, 8'(8'h60 + i), 1'b0}, 8'(8'h60 + i), 1'b1);
      do_enc(8'(8'h90 + i));
    end
    do_rx(10'b1_10011001_0, 8'h99, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_read_enable", {31'h0, read_enable}, 32'h0);
    check("arst_encrypt_enable", {31'h0, encrypt_enable}, 32'h0);
    check("arst_send_enable", {31'h0, send_enable}, 32'h0);
    check("arst_err", {31'h0, err}, 32'h0);
    check("arst_enc_in", {24'h0, enc_in}, 32'h0);
    check("arst_tx_data", {24'h0, tx_data}, 32'h0);
    check("arst_fifo_count", {29'h0, fifo_count}, 32'h0);
    check("arst_frame_err_cnt", {24'h0, frame_err_cnt}, 32'h0);
    check("arst_timeout_cnt", {24'h0, timeout_cnt}, 32'h0);
    exp_q.delete();
    run       = 1'b0;
    hold_busy = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (30) tick();
    check("post_rst_fifo_empty", {29'h0, fifo_count}, 32'h0);
    check("post_rst_no_read", {31'h0, read_enable}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
